oled_spi_responder: RTL and testbench
=====================================

Name: oled_spi_responder

Overview:
- Responder end of the OLED 4-wire SPI link (sck, mosi, dc, cs): oversamples the bus on the system clock, deframes bytes, and decodes the SSD1306 page-addressing command subset.
- Display-data bytes become framebuffer write strobes (page, column).
- Used as a synthesizable display model and bench monitor next to the OLED SPI master, and for loopback checking of the init/draw sequencers on board.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (min 2).
- COLS, 128, display columns; column address width = 7.
- PAGES, 8, display pages; page address width = 3.

Ports:
- clk  in  1  system clock; must be ≥4× sck frequency.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, mode 0: idle low, MOSI sampled on rising edge.
- mosi  in  1  serial data, MSB first.
- dc  in  1  0 = command byte, 1 = display data; sampled with bit 0 of each byte.
- cs  in  1  active-low chip select.
- rx_valid  out  1  one-cycle pulse: a complete byte was received.
- rx_byte  out  8  received byte, valid while rx_valid = 1.
- rx_is_data  out  1  dc value captured for rx_byte.
- fb_we  out  1  one-cycle framebuffer write strobe.
- fb_addr  out  10  {page[2:0], col[6:0]} of the write.
- fb_wdata  out  8  byte to write (bit 0 = top pixel row of the page).
- cur_page  out  3  current page pointer.
- cur_col  out  7  current column pointer.
- cmd_count  out  16  received command bytes, saturating at 0xFFFF.

Behaviour:
- Reset: all outputs 0; bit counter 0; decoder in S_CMD; page/col = 0.
- Synchronize sck, mosi, dc, cs through SYNC_STAGES flops. Edge-detect sck_rise on the synchronized sck.
- On sck_rise with cs_s = 0: shift mosi_s into the shift register and increment the bit counter.
- On the 8th rise: capture dc_s. Next clk: rx_valid = 1, rx_byte/rx_is_data valid, bit counter back to 0.
- cs_s = 1 at any point: clear the bit counter and discard the partial byte, no rx_valid. Decoder state is kept, as on the real panel.
- sck edges while cs_s = 1 are ignored.
- Data byte (rx_is_data = 1): fb_we pulses one clk after rx_valid, with fb_addr = {cur_page, cur_col} and fb_wdata = rx_byte. The same cycle, cur_col increments. Col COLS-1 wraps to 0; page is unchanged (page mode).
- Command decoder FSM, states S_CMD, S_ARG1, S_ARG2. Transitions on command bytes only:
  - S_CMD, 0xB0–0xB7: cur_page = byte[2:0].
  - S_CMD, 0x00–0x0F: cur_col[3:0] = byte[3:0].
  - S_CMD, 0x10–0x17: cur_col[6:4] = byte[2:0].
  - S_CMD, one-argument opcodes 0x20, 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB: go to S_ARG1. Next command byte is swallowed; return to S_CMD.
  - S_CMD, two-argument opcodes 0x21, 0x22: go to S_ARG2 → S_ARG1 → S_CMD.
  - All other command bytes: no pointer effect, stay in S_CMD.
- Data bytes arriving in S_ARG1/S_ARG2 are still written to the framebuffer and do not advance the FSM.
- cmd_count increments on every command byte, arguments included.
- Simultaneous events: cs rising on the same synchronized cycle as the 8th sck_rise completes the byte; the edge is processed before the cs clear.
- Asynchronous reset mid-byte or mid-argument returns everything to reset values immediately.

Optional Feature:
- Macro OLED_RESP_DISPSTATE_EN.
- When defined, adds outputs:
  - disp_on (1): 0xAF sets it, 0xAE clears it, reset 0.
  - contrast (8): argument of 0x81, reset 0x7F.
- When undefined, these ports and registers do not exist; 0xAE/0xAF are plain no-op commands and 0x81 still swallows one argument.

Decomposition:
- Shared package oled_pkg holds:
  - opcode constants: CMD_DISP_OFF 0xAE, CMD_DISP_ON 0xAF, CMD_CONTRAST 0x81, CMD_PAGE_BASE 0xB0, CMD_COL_LO 0x00, CMD_COL_HI 0x10;
  - the one- and two-argument opcode lists;
  - COLS/PAGES defaults;
  - the decoder state enum.
- One sub-module, spi_byte_deframer: synchronizers, edge detect, shift register, bit counter, producing rx_valid/rx_byte/rx_is_data. The top module holds the command decoder and pointers.

Test Plan:
- Command 0xB3, then 0x05, 0x12, then data 0xA5 → fb_we once, fb_addr = {3'd3, 7'd37}, fb_wdata = 0xA5; cur_col = 38; cmd_count = 3.
- Commands 0xB0, 0x0F, 0x17 (col 127), then data 0x11, 0x22 → writes at {0,127} then {0,0}; cur_page stays 0.
- Command 0x81, then command 0xB5 → 0xB5 swallowed as argument; cur_page stays 0. With OLED_RESP_DISPSTATE_EN: contrast = 0xB5.
- Command 0x21 with args 0xB2, 0x07, then 0xB6 → cur_page = 6, cur_col unchanged; cmd_count = 4.
- Send 5 bits, raise cs for 4 clk, send full byte 0x3C as data → exactly one rx_valid with rx_byte = 0x3C.
- Assert reset_n low in S_ARG2 after 3 bits → all outputs 0; the next command byte 0xB1 sets cur_page = 1.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared opcodes, decoder state and geometry defaults for the OLED SPI responder.
// Optional display-state outputs are controlled by OLED_RESP_DISPSTATE_EN.
package oled_pkg;

    localparam int COLS_DEF  = 128;
    localparam int PAGES_DEF = 8;

    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
    localparam logic [7:0] CMD_CONTRAST  = 8'h81;
    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;

    localparam logic [7:0] ONE_ARG_OPS [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                                               8'hD5, 8'hD9, 8'hDA, 8'hDB};
    localparam logic [7:0] TWO_ARG_OPS [2] = '{8'h21, 8'h22};

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_ARG1 = 2'd1,
        S_ARG2 = 2'd2
    } dec_state_e;

    function automatic logic is_one_arg(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (op == ONE_ARG_OPS[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    function automatic logic is_two_arg(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (op == TWO_ARG_OPS[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/spi_byte_deframer.sv
// Oversampling SPI mode-0 receiver: synchronizes the bus, detects sck rises and
// assembles MSB-first bytes, tagging each with the dc level seen on its last bit.
module spi_byte_deframer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       mosi,
    input  logic       dc,
    input  logic       cs,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_is_data
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, cs_prev_q;
    logic [6:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   rx_is_data_q, rx_is_data_d;

    logic sck_s, mosi_s, dc_s, cs_s, sck_rise_s, cs_window_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_q;
    // An edge landing on the very cycle cs rises still belongs to the frame.
    assign cs_window_s = ~cs_s | ~cs_prev_q;

    // Next-state logic for synchronizers, shifter, bit counter and byte outputs
    always_comb begin
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        dc_sync_d    = {dc_sync_q[SYNC_STAGES-2:0], dc};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs};
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        rx_valid_d   = 1'b0;
        rx_byte_d    = rx_byte_q;
        rx_is_data_d = rx_is_data_q;
        if (sck_rise_s && cs_window_s) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_valid_d   = 1'b1;
                rx_byte_d    = {shift_q, mosi_s};
                rx_is_data_d = dc_s;
            end else begin
                rx_valid_d = 1'b0;
            end
        end else begin
            shift_d = shift_q;
        end
        if (cs_s) begin
            bit_cnt_d = 3'd0;
        end else begin
            bit_cnt_d = bit_cnt_d;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q   <= {SYNC_STAGES{1'b0}};
            mosi_sync_q  <= {SYNC_STAGES{1'b0}};
            dc_sync_q    <= {SYNC_STAGES{1'b0}};
            cs_sync_q    <= {SYNC_STAGES{1'b1}};
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            shift_q      <= 7'd0;
            bit_cnt_q    <= 3'd0;
            rx_valid_q   <= 1'b0;
            rx_byte_q    <= 8'd0;
            rx_is_data_q <= 1'b0;
        end else begin
            sck_sync_q   <= sck_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            dc_sync_q    <= dc_sync_d;
            cs_sync_q    <= cs_sync_d;
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_valid_q   <= rx_valid_d;
            rx_byte_q    <= rx_byte_d;
            rx_is_data_q <= rx_is_data_d;
        end
    end

    assign rx_valid   = rx_valid_q;
    assign rx_byte    = rx_byte_q;
    assign rx_is_data = rx_is_data_q;

endmodule

// File: rtl/oled_spi_responder.sv
// SSD1306-style SPI responder: byte deframer plus page-mode command decoder and
// framebuffer write strobes. Define OLED_RESP_DISPSTATE_EN for disp_on/contrast.
module oled_spi_responder
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = COLS_DEF,
    parameter int PAGES       = PAGES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        mosi,
    input  logic        dc,
    input  logic        cs,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        rx_is_data,
    output logic        fb_we,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_wdata,
    output logic [2:0]  cur_page,
    output logic [6:0]  cur_col,
`ifdef OLED_RESP_DISPSTATE_EN
    output logic        disp_on,
    output logic [7:0]  contrast,
`endif
    output logic [15:0] cmd_count
);

    dec_state_e  state_q, state_d;
    logic [2:0]  page_q, page_d;
    logic [6:0]  col_q, col_d;
    logic [15:0] cmd_count_q, cmd_count_d;
    logic        fb_we_q, fb_we_d;
    logic [9:0]  fb_addr_q, fb_addr_d;
    logic [7:0]  fb_wdata_q, fb_wdata_d;
`ifdef OLED_RESP_DISPSTATE_EN
    logic        disp_on_q, disp_on_d;
    logic [7:0]  contrast_q, contrast_d;
    logic        contrast_arg_q, contrast_arg_d;
`endif

    spi_byte_deframer #(.SYNC_STAGES(SYNC_STAGES)) u_deframer (
        .clk        (clk),
        .reset_n    (reset_n),
        .sck        (sck),
        .mosi       (mosi),
        .dc         (dc),
        .cs         (cs),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_is_data (rx_is_data)
    );

    // Decoder next-state, pointer updates and framebuffer strobe
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        col_d       = col_q;
        cmd_count_d = cmd_count_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_wdata_d  = fb_wdata_q;
`ifdef OLED_RESP_DISPSTATE_EN
        disp_on_d      = disp_on_q;
        contrast_d     = contrast_q;
        contrast_arg_d = contrast_arg_q;
`endif
        if (rx_valid && rx_is_data) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = {page_q, col_q};
            fb_wdata_d = rx_byte;
            if (32'(col_q) >= COLS - 1) begin
                col_d = 7'd0;
            end else begin
                col_d = col_q + 7'd1;
            end
        end else if (rx_valid) begin
            if (cmd_count_q != 16'hFFFF) begin
                cmd_count_d = cmd_count_q + 16'd1;
            end else begin
                cmd_count_d = cmd_count_q;
            end
            case (state_q)
                S_CMD: begin
                    if ((rx_byte & 8'hF8) == CMD_PAGE_BASE) begin
                        if (32'(rx_byte[2:0]) < PAGES) begin
                            page_d = rx_byte[2:0];
                        end else begin
                            page_d = page_q;
                        end
                    end else if ((rx_byte & 8'hF0) == CMD_COL_LO) begin
                        col_d = {col_q[6:4], rx_byte[3:0]};
                    end else if ((rx_byte & 8'hF8) == CMD_COL_HI) begin
                        col_d = {rx_byte[2:0], col_q[3:0]};
                    end else if (is_two_arg(rx_byte)) begin
                        state_d = S_ARG2;
                    end else if (is_one_arg(rx_byte)) begin
                        state_d = S_ARG1;
`ifdef OLED_RESP_DISPSTATE_EN
                        contrast_arg_d = (rx_byte == CMD_CONTRAST);
`endif
                    end else begin
`ifdef OLED_RESP_DISPSTATE_EN
                        if (rx_byte == CMD_DISP_ON) begin
                            disp_on_d = 1'b1;
                        end else if (rx_byte == CMD_DISP_OFF) begin
                            disp_on_d = 1'b0;
                        end else begin
                            disp_on_d = disp_on_q;
                        end
`endif
                        state_d = S_CMD;
                    end
                end
                S_ARG2: begin
                    state_d = S_ARG1;
`ifdef OLED_RESP_DISPSTATE_EN
                    contrast_arg_d = 1'b0;
`endif
                end
                S_ARG1: begin
`ifdef OLED_RESP_DISPSTATE_EN
                    if (contrast_arg_q) begin
                        contrast_d = rx_byte;
                    end else begin
                        contrast_d = contrast_q;
                    end
                    contrast_arg_d = 1'b0;
`endif
                    state_d = S_CMD;
                end
                default: begin
                    state_d = S_CMD;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Decoder and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_CMD;
            page_q      <= 3'd0;
            col_q       <= 7'd0;
            cmd_count_q <= 16'd0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= 10'd0;
            fb_wdata_q  <= 8'd0;
`ifdef OLED_RESP_DISPSTATE_EN
            disp_on_q      <= 1'b0;
            contrast_q     <= 8'h7F;
            contrast_arg_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            col_q       <= col_d;
            cmd_count_q <= cmd_count_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_wdata_q  <= fb_wdata_d;
`ifdef OLED_RESP_DISPSTATE_EN
            disp_on_q      <= disp_on_d;
            contrast_q     <= contrast_d;
            contrast_arg_q <= contrast_arg_d;
`endif
        end
    end

    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_wdata  = fb_wdata_q;
    assign cur_page  = page_q;
    assign cur_col   = col_q;
    assign cmd_count = cmd_count_q;
`ifdef OLED_RESP_DISPSTATE_EN
    assign disp_on   = disp_on_q;
    assign contrast  = contrast_q;
`endif

endmodule

// File: tb/tb_oled_spi_responder.sv
// Directed bench for oled_spi_responder: scoreboards for received bytes and
// framebuffer writes plus pointer/counter checks after each command sequence.
module tb_oled_spi_responder;
    import oled_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        dc = 1'b0;
    logic        cs = 1'b1;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_is_data;
    logic        fb_we;
    logic [9:0]  fb_addr;
    logic [7:0]  fb_wdata;
    logic [2:0]  cur_page;
    logic [6:0]  cur_col;
    logic [15:0] cmd_count;
`ifdef OLED_RESP_DISPSTATE_EN
    logic        disp_on;
    logic [7:0]  contrast;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int rx_seen = 0;
    logic [8:0]  rx_exp_q [$];
    logic [17:0] fb_exp_q [$];

    oled_spi_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sck        (sck),
        .mosi       (mosi),
        .dc         (dc),
        .cs         (cs),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_is_data (rx_is_data),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .cur_page   (cur_page),
        .cur_col    (cur_col),
`ifdef OLED_RESP_DISPSTATE_EN
        .disp_on    (disp_on),
        .contrast   (contrast),
`endif
        .cmd_count  (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every received byte and framebuffer write is popped and compared
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                rx_seen++;
                chk("rx_expected", 32'(rx_exp_q.size() > 0), 32'd1);
                if (rx_exp_q.size() > 0) chk("rx_byte", 32'({rx_is_data, rx_byte}), 32'(rx_exp_q.pop_front()));
            end
            if (fb_we) begin
                chk("fb_expected", 32'(fb_exp_q.size() > 0), 32'd1);
                if (fb_exp_q.size() > 0) chk("fb_write", 32'({fb_addr, fb_wdata}), 32'(fb_exp_q.pop_front()));
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input int n, input logic d);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            dc = d;
            repeat (4) @(posedge clk);
            sck = 1'b1;
            repeat (4) @(posedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic d);
        cs = 1'b0;
        rx_exp_q.push_back({d, b});
        spi_bits(b, 8, d);
        repeat (6) @(posedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rx_byte"}, 32'({rx_is_data, rx_byte}), 32'd0);
        chk({tag, "_fb"}, 32'({fb_we, fb_addr, fb_wdata}), 32'd0);
        chk({tag, "_ptr"}, 32'({cur_page, cur_col}), 32'd0);
        chk({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
    endtask

    initial begin
        int rx_before;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
`ifdef OLED_RESP_DISPSTATE_EN
        chk("reset_disp_on", 32'(disp_on), 32'd0);
        chk("reset_contrast", 32'(contrast), 32'h7F);
`endif
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Page 3, column 37, one data byte
        send(8'hB3, 1'b0);
        send(8'h05, 1'b0);
        send(8'h12, 1'b0);
        fb_exp_q.push_back({3'd3, 7'd37, 8'hA5});
        send(8'hA5, 1'b1);
        chk("t1_col", 32'(cur_col), 32'd38);
        chk("t1_page", 32'(cur_page), 32'd3);
        chk("t1_cmd_count", 32'(cmd_count), 32'd3);

        // Column wrap at 127 stays on the same page
        send(8'hB0, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h17, 1'b0);
        chk("t2_col127", 32'(cur_col), 32'd127);
        fb_exp_q.push_back({3'd0, 7'd127, 8'h11});
        send(8'h11, 1'b1);
        fb_exp_q.push_back({3'd0, 7'd0, 8'h22});
        send(8'h22, 1'b1);
        chk("t2_page", 32'(cur_page), 32'd0);
        chk("t2_col", 32'(cur_col), 32'd1);
        chk("t2_cmd_count", 32'(cmd_count), 32'd6);

        // One-argument opcode swallows the page command
        send(8'h81, 1'b0);
        send(8'hB5, 1'b0);
        chk("t3_page", 32'(cur_page), 32'd0);
        chk("t3_cmd_count", 32'(cmd_count), 32'd8);
`ifdef OLED_RESP_DISPSTATE_EN
        chk("t3_contrast", 32'(contrast), 32'hB5);
`endif

        // Two-argument opcode, then a live page command
        send(8'h21, 1'b0);
        send(8'hB2, 1'b0);
        send(8'h07, 1'b0);
        chk("t4_col_held", 32'(cur_col), 32'd1);
        send(8'hB6, 1'b0);
        chk("t4_page", 32'(cur_page), 32'd6);
        chk("t4_col", 32'(cur_col), 32'd1);
        chk("t4_cmd_count", 32'(cmd_count), 32'd12);

        // Partial byte aborted by cs, then a full data byte
        rx_before = rx_seen;
        cs = 1'b0;
        spi_bits(8'hFF, 5, 1'b1);
        cs = 1'b1;
        repeat (4) @(posedge clk);
        fb_exp_q.push_back({3'd6, 7'd1, 8'h3C});
        send(8'h3C, 1'b1);
        chk("t5_one_rx", 32'(rx_seen - rx_before), 32'd1);
        chk("t5_col", 32'(cur_col), 32'd2);
        chk("t5_cmd_count", 32'(cmd_count), 32'd12);

`ifdef OLED_RESP_DISPSTATE_EN
        send(8'hAF, 1'b0);
        chk("disp_on_set", 32'(disp_on), 32'd1);
        send(8'hAE, 1'b0);
        chk("disp_on_clr", 32'(disp_on), 32'd0);
`endif

        // Reset while in S_ARG2 with three bits already shifted
        send(8'h21, 1'b0);
        spi_bits(8'hFF, 3, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_state("t6_async");
`ifdef OLED_RESP_DISPSTATE_EN
        chk("t6_contrast", 32'(contrast), 32'h7F);
`endif
        cs = 1'b1;
        repeat (4) @(posedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        send(8'hB1, 1'b0);
        chk("t6_page", 32'(cur_page), 32'd1);
        chk("t6_cmd_count", 32'(cmd_count), 32'd1);

        cs = 1'b1;
        repeat (4) @(posedge clk);
        chk("rx_q_drained", 32'(rx_exp_q.size()), 32'd0);
        chk("fb_q_drained", 32'(fb_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
